// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; optional 8E1 framing with rx_parity_err under `UART_RX_PARITY_EN
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       rx_parity_err,
`endif
    output logic       rx_busy
);

    localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam logic [15:0] CNT_MID  = 16'(BPS_CNT / 2 - 1);
    localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    logic [2:0]  r_state;
    logic        r_rxd_s1;
    logic        r_rxd_s2;
    logic        r_rxd_d;
    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
`ifdef UART_RX_PARITY_EN
    logic        r_par_bad;
`endif

    logic w_start_edge;
    logic w_in_frame;
    logic w_mid;

    assign w_start_edge = ~r_rxd_s2 & r_rxd_d;
    assign w_in_frame   = (r_state == ST_START) || (r_state == ST_DATA) ||
                          (r_state == ST_PARITY) || (r_state == ST_STOP);
    assign w_mid        = w_in_frame && (r_clk_cnt == CNT_MID);
    assign rx_busy      = (r_state != ST_IDLE);

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_s1 <= 1'b1;
            r_rxd_s2 <= 1'b1;
            r_rxd_d  <= 1'b1;
        end else begin
            r_rxd_s1 <= uart_rxd;
            r_rxd_s2 <= r_rxd_s1;
            r_rxd_d  <= r_rxd_s2;
        end
    end

    // Bit-period counter: free-runs 0..BPS_CNT-1 while inside a frame, held at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_cnt <= 16'd0;
        end else if (!w_in_frame || r_clk_cnt == CNT_LAST) begin
            r_clk_cnt <= 16'd0;
        end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
        end
    end

    // Frame state machine: samples each bit at mid-period and issues single-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad     <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_mid) begin
                        if (r_rxd_s2) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_mid) begin
                        r_shift[r_bit_cnt] <= r_rxd_s2;
                        r_bit_cnt          <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_mid) begin
                        r_par_bad <= ^{r_shift, r_rxd_s2};
                        r_state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_mid) begin
                        if (r_rxd_s2) begin
`ifdef UART_RX_PARITY_EN
                            if (r_par_bad) begin
                                rx_parity_err <= 1'b1;
                            end else begin
                                rx_data  <= r_shift;
                                rx_valid <= 1'b1;
                            end
`else
                            rx_data  <= r_shift;
                            rx_valid <= 1'b1;
`endif
                            r_state <= ST_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            r_state      <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (r_rxd_s2) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed testbench for uart_rx
module tb_uart_rx;

    localparam int BPS = 50_000_000 / 115200;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk;
    logic       rst_n;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    int n_assert;
    int n_fail;
    int cyc;
    int valid_cnt;
    int ferr_cnt;
    int perr_cnt;
    int overlap_cnt;
    int long_cnt;
    int valid_cyc[$];
    logic [7:0] valid_dat[$];
    logic prev_valid;
    logic prev_ferr;

    uart_rx #(.CLK_FREQ(50_000_000), .UART_BPS(115200)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rxd     (uart_rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
`ifdef UART_RX_PARITY_EN
        .rx_parity_err(rx_parity_err),
`endif
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc.push_back(cyc);
            valid_dat.push_back(rx_data);
        end
        if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (rx_parity_err) perr_cnt <= perr_cnt + 1;
`endif
        if (rx_valid && rx_frame_err) overlap_cnt <= overlap_cnt + 1;
        if ((rx_valid && prev_valid) || (rx_frame_err && prev_ferr)) long_cnt <= long_cnt + 1;
        prev_valid <= rx_valid;
        prev_ferr  <= rx_frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        repeat (BPS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) uart_rxd = 1'b1;
`endif
        drive_bit(stop);
    endtask

    int base_v;
    int base_f;
    int t0;
    int waited;

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0;
        valid_cnt = 0; ferr_cnt = 0; perr_cnt = 0;
        overlap_cnt = 0; long_cnt = 0;
        prev_valid = 1'b0; prev_ferr = 1'b0;
        uart_rxd = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // single frame 0x55
        send_frame(8'h55, ^8'h55, 1'b1);
        repeat (BPS) @(negedge clk);
        check("f55_valid_cnt", valid_cnt, 1);
        check("f55_captured", {24'd0, valid_dat[0]}, 32'h55);
        check("f55_rx_data", {24'd0, rx_data}, 32'h55);
        check("f55_ferr_cnt", ferr_cnt, 0);
        check("f55_idle", {31'd0, rx_busy}, 32'd0);

        // back-to-back 0xA5, 0x3C with no idle gap
        send_frame(8'hA5, ^8'hA5, 1'b1);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        repeat (BPS) @(negedge clk);
        check("b2b_valid_cnt", valid_cnt, 3);
        check("b2b_first", {24'd0, valid_dat[1]}, 32'hA5);
        check("b2b_second", {24'd0, valid_dat[2]}, 32'h3C);
        check("b2b_spacing", valid_cyc[2] - valid_cyc[1], FRAME_BITS * BPS);
        check("b2b_rx_data", {24'd0, rx_data}, 32'h3C);

        // false start: 100 clocks low
        base_v = valid_cnt; base_f = ferr_cnt;
        t0 = cyc;
        uart_rxd = 1'b0;
        repeat (50) @(negedge clk);
        check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
        repeat (50) @(negedge clk);
        uart_rxd = 1'b1;
        waited = 0;
        while (rx_busy && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check("glitch_busy_timeout", {31'd0, rx_busy}, 32'd0);
        check("glitch_busy_drop_window", ((cyc - t0) >= 212 && (cyc - t0) <= 226) ? 32'd1 : 32'd0, 32'd1);
        repeat (BPS) @(negedge clk);
        check("glitch_no_valid", valid_cnt, base_v);
        check("glitch_no_ferr", ferr_cnt, base_f);

        // framing error: 0xFF with low stop bit, line held low 2 more bit-times
        send_frame(8'hFF, ^8'hFF, 1'b0);
        repeat (2 * BPS) @(negedge clk);
        check("ferr_cnt", ferr_cnt, base_f + 1);
        check("ferr_no_valid", valid_cnt, base_v);
        check("ferr_rx_data_kept", {24'd0, rx_data}, 32'h3C);
        check("ferr_break_busy", {31'd0, rx_busy}, 32'd1);
        uart_rxd = 1'b1;
        repeat (6) @(negedge clk);
        check("ferr_break_exit", {31'd0, rx_busy}, 32'd0);
        repeat (2 * BPS) @(negedge clk);
        check("ferr_no_new_frame", valid_cnt, base_v);
        check("ferr_single_pulse", ferr_cnt, base_f + 1);

        // reset in the middle of the data bits of 0x81
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_mid_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_mid_ferr", {31'd0, rx_frame_err}, 32'd0);
        uart_rxd = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (BPS) @(negedge clk);
        check("rst_no_strobe", valid_cnt, base_v);
        send_frame(8'h42, ^8'h42, 1'b1);
        repeat (BPS) @(negedge clk);
        check("post_rst_valid_cnt", valid_cnt, base_v + 1);
        check("post_rst_rx_data", {24'd0, rx_data}, 32'h42);

`ifdef UART_RX_PARITY_EN
        check("par_err_idle", {31'd0, rx_parity_err}, 32'd0);
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (BPS) @(negedge clk);
        check("par_good_valid", valid_cnt, base_v + 2);
        check("par_good_data", {24'd0, rx_data}, 32'h07);
        check("par_good_no_perr", perr_cnt, 0);
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (BPS) @(negedge clk);
        check("par_bad_perr", perr_cnt, 1);
        check("par_bad_no_valid", valid_cnt, base_v + 2);
        check("par_bad_data_kept", {24'd0, rx_data}, 32'h07);
`endif

        check("strobe_overlap", overlap_cnt, 0);
        check("strobe_length", long_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
